// File: rtl/bomberman_pkg.sv
// Shared encodings for the bomberman game blocks: facing direction, motion FSM
// states, blocked-flag bit positions and screen geometry.
package bomberman_pkg;

  localparam int SCR_W   = 640;
  localparam int SCR_H   = 480;
  localparam int SCR_TOP = 16;

  typedef enum logic [1:0] {
    DIR_DOWN  = 2'd0,
    DIR_UP    = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEFT,
    ST_RIGHT,
    ST_UP,
    ST_DOWN
  } state_e;

  // Bit positions inside the {left,right,up,down} blocked vector
  localparam int BLK_L = 3;
  localparam int BLK_R = 2;
  localparam int BLK_U = 1;
  localparam int BLK_D = 0;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: counts 0..DIV-1 and pulses tick for one clock on the
// last count before wrapping.
module tick_gen #(
  parameter int DIV = 800000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else                    r_cnt <= r_cnt + CW'(1);
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/sprite_motion.sv
// Player sprite motion: button-driven direction FSM, clamped stepping on move
// ticks, walk-frame animation and a combinational sprite hit/ROM address.
module sprite_motion import bomberman_pkg::*; #(
  parameter int SPR_W      = 16,
  parameter int SPR_H      = 16,
  parameter int X_MIN      = 0,
  parameter int X_MAX      = SCR_W,
  parameter int Y_MIN      = SCR_TOP,
  parameter int Y_MAX      = SCR_H,
  parameter int START_X    = 144,
  parameter int START_Y    = 400,
  parameter int STEP       = 1,
  parameter int MOVE_DIV   = 800000,
  parameter int ANIM_TICKS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     btn_l,
  input  logic                     btn_r,
  input  logic                     btn_u,
  input  logic                     btn_d,
  input  logic [3:0]               blocked,
  input  logic                     freeze,
  input  logic [9:0]               v_x,
  input  logic [9:0]               v_y,
  output logic [9:0]               pos_x,
  output logic [9:0]               pos_y,
  output logic [1:0]               dir,
  output logic                     moving,
  output logic [1:0]               frame,
  output logic                     sprite_on,
  output logic [$clog2(SPR_H)-1:0] rom_row,
  output logic [$clog2(SPR_W)-1:0] rom_col
);

  localparam int XW   = $clog2(SPR_W);
  localparam int YW   = $clog2(SPR_H);
  localparam int X_HI = X_MAX - SPR_W;
  localparam int Y_HI = Y_MAX - SPR_H;
  localparam int AW   = (ANIM_TICKS > 1) ? $clog2(ANIM_TICKS) : 1;

  if (START_X < X_MIN || START_X > X_HI || START_Y < Y_MIN || START_Y > Y_HI) begin : g_bad_start
    $error("sprite_motion: START position outside the legal span");
  end

  state_e          r_state, w_state_nxt;
  dir_e            r_dir, w_dir_nxt;
  logic [9:0]      r_x, r_y, w_nx, w_ny;
  logic [1:0]      r_frame;
  logic [AW-1:0]   r_anim;
  logic            w_tick, w_blk, w_move, w_eff, w_to_idle;
  logic [10:0]     w_xp, w_yp, w_xe, w_ye;

  tick_gen #(.DIV(MOVE_DIV)) u_tick (.clk(clk), .reset(reset), .tick(w_tick));

  // Leaving IDLE picks the highest-priority button; a movement state only
  // watches its own button.
  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    unique case (r_state)
      ST_IDLE: begin
        if      (btn_l) begin w_state_nxt = ST_LEFT;  w_dir_nxt = DIR_LEFT;  end
        else if (btn_r) begin w_state_nxt = ST_RIGHT; w_dir_nxt = DIR_RIGHT; end
        else if (btn_u) begin w_state_nxt = ST_UP;    w_dir_nxt = DIR_UP;    end
        else if (btn_d) begin w_state_nxt = ST_DOWN;  w_dir_nxt = DIR_DOWN;  end
      end
      ST_LEFT:  if (!btn_l) w_state_nxt = ST_IDLE;
      ST_RIGHT: if (!btn_r) w_state_nxt = ST_IDLE;
      ST_UP:    if (!btn_u) w_state_nxt = ST_IDLE;
      ST_DOWN:  if (!btn_d) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_xp = {1'b0, r_x} + 11'(STEP);
  assign w_yp = {1'b0, r_y} + 11'(STEP);

  // Decrements compare before subtracting, so the low edge never wraps
  always_comb begin
    w_nx  = r_x;
    w_ny  = r_y;
    w_blk = 1'b1;
    case (r_state)
      ST_LEFT: begin
        w_blk = blocked[BLK_L];
        w_nx  = ({1'b0, r_x} < 11'(X_MIN + STEP)) ? 10'(X_MIN) : 10'({1'b0, r_x} - 11'(STEP));
      end
      ST_RIGHT: begin
        w_blk = blocked[BLK_R];
        w_nx  = (w_xp > 11'(X_HI)) ? 10'(X_HI) : w_xp[9:0];
      end
      ST_UP: begin
        w_blk = blocked[BLK_U];
        w_ny  = ({1'b0, r_y} < 11'(Y_MIN + STEP)) ? 10'(Y_MIN) : 10'({1'b0, r_y} - 11'(STEP));
      end
      ST_DOWN: begin
        w_blk = blocked[BLK_D];
        w_ny  = (w_yp > 11'(Y_HI)) ? 10'(Y_HI) : w_yp[9:0];
      end
      default: ;
    endcase
  end

  assign w_move    = w_tick && !freeze && !w_blk;
  assign w_eff     = w_move && ((w_nx != r_x) || (w_ny != r_y));
  assign w_to_idle = (r_state != ST_IDLE) && (w_state_nxt == ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_dir   <= DIR_DOWN;
      r_x     <= 10'(START_X);
      r_y     <= 10'(START_Y);
      r_frame <= '0;
      r_anim  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dir   <= w_dir_nxt;
      if (w_move) begin
        r_x <= w_nx;
        r_y <= w_ny;
      end
      if (w_to_idle) begin
        r_frame <= '0;
        r_anim  <= '0;
      end else if (w_eff) begin
        if (r_anim == AW'(ANIM_TICKS - 1)) begin
          r_anim  <= '0;
          r_frame <= r_frame + 2'd1;
        end else begin
          r_anim  <= r_anim + AW'(1);
        end
      end
    end
  end

  assign pos_x  = r_x;
  assign pos_y  = r_y;
  assign dir    = r_dir;
  assign frame  = r_frame;
  assign moving = (r_state != ST_IDLE) && !freeze;

  assign w_xe      = {1'b0, r_x} + 11'(SPR_W - 1);
  assign w_ye      = {1'b0, r_y} + 11'(SPR_H - 1);
  assign sprite_on = (v_x >= r_x) && ({1'b0, v_x} <= w_xe) &&
                     (v_y >= r_y) && ({1'b0, v_y} <= w_ye);
  assign rom_col   = sprite_on ? XW'(v_x - r_x) : '0;
  assign rom_row   = sprite_on ? YW'(v_y - r_y) : '0;

endmodule

// File: tb/tb_sprite_motion.sv
// Bench for sprite_motion: pixel-hit table, directed motion sequences and a
// randomized run against a behavioural model of the sprite.
module tb_sprite_motion;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_l = 1'b0, btn_r = 1'b0, btn_u = 1'b0, btn_d = 1'b0;
  logic [3:0] blocked = 4'b0;
  logic freeze = 1'b0;
  logic [9:0] v_x = '0, v_y = '0;

  logic [9:0] p1x, p1y, p2x, p2y;
  logic [1:0] dir1, dir2, frm1, frm2;
  logic       mov1, mov2, on1, on2;
  logic [3:0] row1, col1, row2, col2;

  always #5 clk = ~clk;

  sprite_motion #(.MOVE_DIV(4), .ANIM_TICKS(2)) d1 (
    .clk(clk), .reset(reset), .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d),
    .blocked(blocked), .freeze(freeze), .v_x(v_x), .v_y(v_y),
    .pos_x(p1x), .pos_y(p1y), .dir(dir1), .moving(mov1), .frame(frm1),
    .sprite_on(on1), .rom_row(row1), .rom_col(col1));

  sprite_motion #(.MOVE_DIV(4), .ANIM_TICKS(2), .START_X(1), .STEP(2)) d2 (
    .clk(clk), .reset(reset), .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d),
    .blocked(blocked), .freeze(freeze), .v_x(v_x), .v_y(v_y),
    .pos_x(p2x), .pos_y(p2y), .dir(dir2), .moving(mov2), .frame(frm2),
    .sprite_on(on2), .rom_row(row2), .rom_col(col2));

  // mode: 0 idle, 1 left, 2 right, 3 up, 4 down; eff counts effective moves since idle
  typedef struct {int x; int y; int mode; int dir; int eff; int cyc; int step;} mdl_t;
  mdl_t m1, m2;

  typedef struct {int vx; int vy; int on; int row; int col;} pix_t;
  pix_t pix[6];

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  task automatic mdl_reset(inout mdl_t m, input int sx, input int step);
    m.x = sx; m.y = 400; m.mode = 0; m.dir = 0; m.eff = 0; m.cyc = 0; m.step = step;
  endtask

  task automatic mdl_step(inout mdl_t m);
    bit tick, blk, held;
    int nx, ny;
    tick = (m.cyc % 4) == 3;
    m.cyc++;
    nx = m.x; ny = m.y; blk = 1'b1; held = 1'b0;
    case (m.mode)
      1: begin blk = blocked[3]; held = btn_l; nx = clampi(m.x - m.step, 0, 624);  end
      2: begin blk = blocked[2]; held = btn_r; nx = clampi(m.x + m.step, 0, 624);  end
      3: begin blk = blocked[1]; held = btn_u; ny = clampi(m.y - m.step, 16, 464); end
      4: begin blk = blocked[0]; held = btn_d; ny = clampi(m.y + m.step, 16, 464); end
      default: ;
    endcase
    if (m.mode != 0 && tick && !freeze && !blk && (nx != m.x || ny != m.y)) begin
      m.x = nx; m.y = ny; m.eff++;
    end
    if (m.mode == 0) begin
      if      (btn_l) begin m.mode = 1; m.dir = 2; end
      else if (btn_r) begin m.mode = 2; m.dir = 3; end
      else if (btn_u) begin m.mode = 3; m.dir = 1; end
      else if (btn_d) begin m.mode = 4; m.dir = 0; end
    end else if (!held) begin
      m.mode = 0; m.eff = 0;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    {btn_l, btn_r, btn_u, btn_d} = 4'b0;
    blocked = 4'b0; freeze = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    mdl_reset(m1, 144, 1);
    mdl_reset(m2, 1, 2);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      mdl_step(m1);
      mdl_step(m2);
    end
    @(negedge clk);
  endtask

  task automatic check_model(input int it);
    int on, ex_row, ex_col;
    on = (int'(v_x) >= m1.x && int'(v_x) <= m1.x + 15 && int'(v_y) >= m1.y && int'(v_y) <= m1.y + 15) ? 1 : 0;
    ex_col = on ? int'(v_x) - m1.x : 0;
    ex_row = on ? int'(v_y) - m1.y : 0;
    chk($sformatf("rnd%0d pos_x d1", it), p1x, m1.x);
    chk($sformatf("rnd%0d pos_y d1", it), p1y, m1.y);
    chk($sformatf("rnd%0d dir d1", it), dir1, m1.dir);
    chk($sformatf("rnd%0d frame d1", it), frm1, (m1.eff / 2) % 4);
    chk($sformatf("rnd%0d moving d1", it), mov1, (m1.mode != 0 && !freeze) ? 1 : 0);
    chk($sformatf("rnd%0d sprite_on d1", it), on1, on);
    chk($sformatf("rnd%0d rom d1", it), {row1, col1}, ex_row * 16 + ex_col);
    chk($sformatf("rnd%0d pos_x d2", it), p2x, m2.x);
    chk($sformatf("rnd%0d pos_y d2", it), p2y, m2.y);
    chk($sformatf("rnd%0d frame d2", it), frm2, (m2.eff / 2) % 4);
  endtask

  initial begin
    pix[0] = '{144, 400, 1, 0, 0};
    pix[1] = '{160, 400, 0, 0, 0};
    pix[2] = '{159, 415, 1, 15, 15};
    pix[3] = '{143, 400, 0, 0, 0};
    pix[4] = '{144, 416, 0, 0, 0};
    pix[5] = '{150, 405, 1, 5, 6};

    // Reset state and pixel hit table
    apply_reset();
    chk("rst pos_x", p1x, 144);
    chk("rst pos_y", p1y, 400);
    chk("rst dir", dir1, 0);
    chk("rst frame", frm1, 0);
    chk("rst moving", mov1, 0);
    chk("rst pos_x d2", p2x, 1);
    for (int i = 0; i < 6; i++) begin
      v_x = 10'(pix[i].vx); v_y = 10'(pix[i].vy);
      #1;
      chk($sformatf("pix%0d sprite_on", i), on1, pix[i].on);
      chk($sformatf("pix%0d rom_row", i), row1, pix[i].row);
      chk($sformatf("pix%0d rom_col", i), col1, pix[i].col);
    end

    // Hold left 12 clocks; d2 starts one pixel off the edge with STEP 2
    apply_reset();
    btn_l = 1'b1;
    cyc(4);
    chk("left first tick x", p1x, 143);
    chk("clamp d2 x first tick", p2x, 0);
    cyc(8);
    chk("left12 x", p1x, 141);
    chk("left12 dir", dir1, 2);
    chk("left12 frame", frm1, 1);
    chk("left12 moving", mov1, 1);
    chk("clamp d2 x held", p2x, 0);
    chk("clamp d2 frame", frm2, 0);

    // Blocked and frozen
    apply_reset();
    btn_l = 1'b1; blocked = 4'b1000;
    cyc(12);
    chk("blocked x", p1x, 144);
    chk("blocked moving", mov1, 1);
    apply_reset();
    btn_r = 1'b1; freeze = 1'b1;
    cyc(12);
    chk("freeze x", p1x, 144);
    chk("freeze moving", mov1, 0);
    chk("freeze dir", dir1, 3);
    freeze = 1'b0;
    cyc(4);
    chk("unfreeze x", p1x, 145);
    chk("unfreeze moving", mov1, 1);

    // Priority and the idle gap between directions
    apply_reset();
    btn_l = 1'b1; btn_u = 1'b1;
    cyc(1);
    chk("prio dir", dir1, 2);
    btn_l = 1'b0;
    cyc(1);
    chk("gap moving", mov1, 0);
    cyc(1);
    chk("up dir", dir1, 1);
    chk("up moving", mov1, 1);
    cyc(5);
    chk("up y", p1y, 398);
    chk("up x", p1x, 144);

    // Asynchronous reset between edges
    apply_reset();
    btn_r = 1'b1;
    cyc(8);
    chk("pre-reset x", p1x, 146);
    chk("pre-reset frame", frm1, 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async reset x", p1x, 144);
    chk("async reset frame", frm1, 0);
    chk("async reset dir", dir1, 0);

    // Randomized run against the model
    apply_reset();
    for (int it = 0; it < 600; it++) begin
      if ($urandom_range(0, 5) == 0) btn_l = ~btn_l;
      if ($urandom_range(0, 5) == 0) btn_r = ~btn_r;
      if ($urandom_range(0, 5) == 0) btn_u = ~btn_u;
      if ($urandom_range(0, 5) == 0) btn_d = ~btn_d;
      freeze = ($urandom_range(0, 9) == 0);
      for (int b = 0; b < 4; b++) blocked[b] = ($urandom_range(0, 3) == 0);
      cyc(1);
      begin
        int vx, vy;
        vx = m1.x + int'($urandom_range(0, 20)) - 2;
        vy = m1.y + int'($urandom_range(0, 20)) - 2;
        v_x = 10'(clampi(vx, 0, 1023));
        v_y = 10'(clampi(vy, 0, 1023));
      end
      #1;
      check_model(it);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
